// File: rtl/alu_arb_pkg.sv
// Shared types and opcode constants for the ALU arbiter.
// The FSM state and one-hot helper live here so the top and grant logic agree.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_NAND = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_SUB  = 4'b1010;
   localparam logic [3:0] OP_NOTI = 4'b1011;

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] r;
      r = '0;
      unique case (1'b1)
         oh[3]:   r = 2'd3;
         oh[2]:   r = 2'd2;
         oh[1]:   r = 2'd1;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational one-hot grant: searches req starting one past ptr, wrapping.
// Pinning ptr to NREQ-1 turns this into lowest-index-wins priority.
module alu_arb_grant #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt
);

   localparam int PW = $clog2(NREQ);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU among NREQ requesters, one op in flight.
// Define ALU_ARB_RR_EN for round-robin grants; default is fixed priority.
module alu_arbiter #(
   parameter int NREQ    = 2,
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [4*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_carry,
   output logic                  rsp_zero,
   output logic                  rsp_sign,
   output logic [3:0]            alu_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_out,
   input  logic                  alu_carry,
   output logic                  busy
);

   import alu_arb_pkg::*;

   localparam int PW = $clog2(NREQ);
   localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_t          state;
   logic [LW-1:0]   lat_cnt;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] sel;
   logic [PW-1:0]   ptr;
   logic [3:0]      op_m;
   logic [WIDTH-1:0] a_m;
   logic [WIDTH-1:0] b_m;

   alu_arb_grant #(
      .NREQ (NREQ)
   ) u_grant (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt)
   );

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= PW'(NREQ - 1);
      end else if (state == IDLE && |gnt) begin
         ptr <= PW'(oh2idx(4'(gnt)));
      end
   end
`else
   assign ptr = PW'(NREQ - 1);
`endif

   always_comb begin
      op_m = '0;
      a_m  = '0;
      b_m  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            op_m = op_m | req_op[4*i +: 4];
            a_m  = a_m | req_a[WIDTH*i +: WIDTH];
            b_m  = b_m | req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   // Accept is same-cycle so the requester's operands are latched as it sees ready.
   assign req_ready = (reset && state == IDLE) ? gnt : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         sel       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_zero  <= 1'b0;
         rsp_sign  <= 1'b0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|gnt) begin
                  sel     <= gnt;
                  alu_op  <= op_m;
                  alu_a   <= a_m;
                  alu_b   <= b_m;
                  lat_cnt <= LW'(ALU_LAT - 1);
                  state   <= EXEC;
               end
            end
            EXEC: begin
               if (lat_cnt == '0) begin
                  rsp_data  <= alu_out;
                  rsp_zero  <= (alu_out == '0);
                  rsp_sign  <= alu_out[WIDTH-1];
                  rsp_carry <= (alu_op == OP_ADD) && alu_carry;
                  rsp_valid <= sel;
                  state     <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RESP: begin
               if (|(rsp_valid & rsp_ready)) begin
                  rsp_valid <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: random and directed requests,
// expected grants and results from a behavioural model of the rules.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 32;
   localparam int LAT  = 1;
`ifdef ALU_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;

   logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [4*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_a, req_b;
   logic [W-1:0]      rsp_data, alu_a, alu_b, alu_out;
   logic              rsp_carry, rsp_zero, rsp_sign, alu_carry, busy;
   logic [3:0]        alu_op;

   logic [3:0]   v2, rr2, rv2, rsr2;
   logic [15:0]  op2;
   logic [127:0] a2, b2;
   logic [W-1:0] d2, aa2, ab2, ao2;
   logic         c2, z2, s2, ac2, busy2;
   logic [3:0]   aop2;
   logic [W:0]   p1, p2;

   typedef struct {
      int          idx;
      int          due;
      logic [W+2:0] rsp;
   } exp_t;

   exp_t            q[$];
   int              glog[$];
   int              last_g;
   logic [W+2:0]    last_rsp;
   logic [NREQ-1:0] done;
   bit              mon_busy;
   int              mon_g;

   alu_arbiter #(.NREQ(NREQ), .WIDTH(W), .ALU_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry),
      .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
   );

   alu_arbiter #(.NREQ(4), .WIDTH(W), .ALU_LAT(3)) dut3 (
      .clk(clk), .reset(reset),
      .req_valid(v2), .req_ready(rr2),
      .req_op(op2), .req_a(a2), .req_b(b2),
      .rsp_valid(rv2), .rsp_ready(rsr2),
      .rsp_data(d2), .rsp_carry(c2),
      .rsp_zero(z2), .rsp_sign(s2),
      .alu_op(aop2), .alu_a(aa2), .alu_b(ab2),
      .alu_out(ao2), .alu_carry(ac2), .busy(busy2)
   );

   function automatic logic [W:0] alu_f(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         4'd0:  r = s[W-1:0];
         4'd1:  r = a & b;
         4'd2:  r = a | b;
         4'd3:  r = a << b[4:0];
         4'd4:  r = a >> b[4:0];
         4'd5:  r = $signed(a) >>> b[4:0];
         4'd6:  r = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
         4'd7:  r = {{(W-1){1'b0}}, a < b};
         4'd8:  r = ~(a & b);
         4'd9:  r = a ^ b;
         4'd10: r = a - b;
         4'd11: r = ~a;
         default: r = '0;
      endcase
      return {s[W], r};
   endfunction

   function automatic logic [W+2:0] exp_rsp(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      logic [W:0] r;
      r = alu_f(op, a, b);
      return {r[W-1:0], (op == 4'b0000) ? r[W] : 1'b0, r[W-1:0] == '0, r[W-1]};
   endfunction

   function automatic int model_grant(logic [NREQ-1:0] v, int last);
      int start;
      start = RR_MODE ? last + 1 : 0;
      for (int k = 0; k < NREQ; k++)
         if (v[(start + k) % NREQ]) return (start + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(int i);
      return (i < 0) ? '0 : NREQ'(1) << i;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      case ($urandom_range(3))
         0: r = '0;
         1: r = '1;
         2: r = W'($urandom_range(40));
         default: r = W'($urandom);
      endcase
      return r;
   endfunction

   function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External ALU models: combinational for dut, two register stages for dut3.
   assign {alu_carry, alu_out} = alu_f(alu_op, alu_a, alu_b);
   always @(posedge clk) begin
      p1 <= alu_f(aop2, aa2, ab2);
      p2 <= p1;
   end
   assign {ac2, ao2} = p2;

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp", {rsp_data, rsp_carry, rsp_zero, rsp_sign}, 0);
         chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
         chk("rst_busy", busy, 0);
         q.delete();
         last_g   = NREQ - 1;
         last_rsp = '0;
      end else begin
         mon_busy = (q.size() != 0);
         chk("busy", busy, mon_busy);
         if (mon_busy && cyc >= q[0].due) begin
            chk("rsp_valid", rsp_valid, oh(q[0].idx));
            chk("rsp_bundle", {rsp_data, rsp_carry, rsp_zero, rsp_sign}, q[0].rsp);
            if (rsp_valid[q[0].idx] && rsp_ready[q[0].idx]) begin
               last_rsp = q[0].rsp;
               void'(q.pop_front());
            end
         end else begin
            chk("rsp_valid_quiet", rsp_valid, 0);
            chk("rsp_hold", {rsp_data, rsp_carry, rsp_zero, rsp_sign}, last_rsp);
         end
         mon_g = mon_busy ? -1 : model_grant(req_valid, last_g);
         chk("req_ready", req_ready, oh(mon_g));
         if (mon_g >= 0) begin
            q.push_back('{idx: mon_g, due: cyc + 1 + LAT,
                          rsp: exp_rsp(req_op[4*mon_g +: 4], req_a[W*mon_g +: W], req_b[W*mon_g +: W])});
            last_g = mon_g;
            glog.push_back(mon_g);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(int i, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      step();
      req_op[4*i +: 4] = op;
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
      req_valid[i]     = 1'b1;
      #1;
      for (int k = 0; k < 40 && !req_ready[i]; k++) step();
      chk("issue_accept", req_ready[i], 1);
      step();
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp();
      for (int k = 0; k < 40 && rsp_valid == '0; k++) step();
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && (busy || q.size() != 0); k++) step();
      chk("idle_reached", busy, 0);
   endtask

   task automatic drive_cycle(int pv, int pr);
      step();
      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i] || done[i]) begin
            req_valid[i]     = ($urandom_range(99) < pv);
            req_op[4*i +: 4] = 4'($urandom);
            req_a[W*i +: W]  = rnd();
            req_b[W*i +: W]  = rnd();
         end
         rsp_ready[i] = ($urandom_range(99) < pr);
      end
      #1;
      done = req_ready;
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      cyc = 0; checks = 0; failures = 0;
      reset = 1'b0;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
      v2 = '0; op2 = '0; a2 = '0; b2 = '0; rsr2 = '0;
      done = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      rsp_ready = '1;
      issue(0, 4'b0000, 32'hFFFF_FFFF, 32'h1);
      wait_rsp();
      chk("add_valid", rsp_valid, 2'b01);
      chk("add_data", rsp_data, 0);
      chk("add_zero", rsp_zero, 1);
      chk("add_carry", rsp_carry, 1);
      wait_idle();

      issue(1, 4'b1010, 32'd5, 32'd7);
      wait_rsp();
      chk("sub_valid", rsp_valid, 2'b10);
      chk("sub_data", rsp_data, 32'hFFFF_FFFE);
      chk("sub_sign", rsp_sign, 1);
      chk("sub_carry", rsp_carry, 0);
      wait_idle();

      glog.delete();
      done = '0;
      for (int k = 0; k < 80 && glog.size() < 4; k++) drive_cycle(100, 100);
      step();
      req_valid = '0;
      rsp_ready = '1;
      wait_idle();
      chk("grant_count", glog.size() >= 4, 1);
      for (int k = 0; k < 4 && k < glog.size(); k++)
         chk("grant_order", glog[k], RR_MODE ? k % 2 : 0);

      rsp_ready = '0;
      issue(0, 4'b0011, 32'h55, 32'd3);
      wait_rsp();
      req_valid[1] = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         chk("stall_valid", rsp_valid, 2'b01);
         chk("stall_data", rsp_data, 32'h2A8);
         chk("stall_busy", busy, 1);
         chk("stall_ready", req_ready, 0);
         step();
      end
      req_valid[1] = 1'b0;
      rsp_ready = 2'b10;
      step();
      step();
      chk("wrong_idx_ignored", rsp_valid, 2'b01);
      rsp_ready = '1;
      wait_idle();

      done = '0;
      for (int k = 0; k < 500; k++) drive_cycle(40, 60);
      step();
      req_valid = '0;
      rsp_ready = '1;
      wait_idle();

      step();
      op2[3:0] = 4'b1001;
      a2[31:0] = 32'hF0;
      b2[31:0] = 32'h0F;
      rsr2 = '1;
      v2 = 4'b0001;
      #1;
      n = -1;
      for (int k = 0; k < 20 && n < 0; k++) begin
         if (rr2[0]) n = cyc;
         else step();
      end
      chk("lat3_accept", rr2[0], 1);
      step();
      v2 = '0;
      for (int k = 0; k < 20 && rv2 == '0; k++) step();
      chk("lat3_latency", cyc - n, 4);
      chk("lat3_valid", rv2, 4'b0001);
      chk("lat3_data", d2, 32'hFF);
      chk("lat3_zero", z2, 0);
      step();
      step();

      issue(0, 4'b0000, 32'h1234, 32'h1);
      reset = 1'b0;
      #1;
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_alu", {alu_op, alu_a, alu_b}, 0);
      chk("async_rsp_data", rsp_data, 0);
      step();
      step();
      reset = 1'b1;
      for (int k = 0; k < 8; k++) step();
      chk("post_reset_quiet", rsp_valid, 0);
      chk("post_reset_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters sharing the ALU (2..4).
REQ-002 SHALL have parameter WIDTH, default 32: operand/result width.
REQ-003 SHALL have parameter ALU_LAT, default 1: cycles from ALU input drive to sampled result (1..4).
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ: per-requester operation request.
REQ-007 SHALL have port req_ready  output  NREQ: one-hot accept pulse to the granted requester.
REQ-008 SHALL have port req_op  input  4*NREQ: per-requester 4-bit ALU opcode, requester i in bits [4i+3:4i].
REQ-009 SHALL have ports req_a and req_b  input  WIDTH*NREQ: per-requester signed operands, packed as req_op.
REQ-010 SHALL have port rsp_valid  output  NREQ: result valid for requester i.
REQ-011 SHALL have port rsp_ready  input  NREQ: requester i consumes result.
REQ-012 SHALL have port rsp_data  output  WIDTH: registered result, shared by all requesters.
REQ-013 SHALL have ports rsp_carry, rsp_zero, rsp_sign  output  1 each: registered flags for rsp_data.
REQ-014 SHALL have ports alu_op  output  4, alu_a and alu_b  output  WIDTH: registered drive to the shared ALU.
REQ-015 SHALL have ports alu_out  input  WIDTH and alu_carry  input  1: ALU result and adder carry-out.
REQ-016 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-018 IDLE: if any req_valid, SHALL grant one requester, pulse its req_ready for that cycle, register its op/a/b onto alu_op/alu_a/alu_b, load lat_cnt=ALU_LAT-1, go EXEC.
REQ-019 IDLE with no req_valid: SHALL remain IDLE, req_ready all zero, alu_* hold.
REQ-020 EXEC: SHALL decrement lat_cnt each cycle; at lat_cnt==0 SHALL capture alu_out into rsp_data and go RESP.
REQ-021 At capture: rsp_zero SHALL be (alu_out==0), rsp_sign SHALL be alu_out[WIDTH-1], rsp_carry SHALL be alu_carry when alu_op==4'b0000, else 0.
REQ-022 RESP: rsp_valid SHALL be high only at the granted index; on rsp_ready at that index SHALL return to IDLE the next cycle.
REQ-023 Latency: accept at cycle N SHALL give rsp_valid at cycle N+1+ALU_LAT; one operation in flight at most.
REQ-024 No new grant SHALL occur in EXEC or RESP; req_valid from others SHALL be held by requesters (no drop, no queue).
REQ-025 Opcodes 4'b1100-4'b1111 SHALL be issued unchanged; result is whatever the ALU returns (0).
REQ-026 rsp_ready at a non-granted index, or in IDLE/EXEC, SHALL be ignored.
REQ-027 rsp_data/flags SHALL hold their value from RESP until the next capture.

Reset
REQ-028 On reset low, asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, rsp_sign=0, alu_op=0, alu_a=0, alu_b=0, lat_cnt=0, rr pointer=NREQ-1, busy=0.
REQ-029 Reset asserted mid-EXEC or mid-RESP SHALL abandon the operation; no rsp_valid after release.

Configuration
REQ-030 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; pointer updates on each grant.
REQ-031 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority, lowest index wins; no pointer register.

Structure
REQ-032 Shared package alu_arb_pkg SHALL hold the FSM state typedef and ALU opcode constants (ADD=4'b0000 ... NOTI=4'b1011).
REQ-033 Grant selection SHALL be a sub-module alu_arb_grant (req vector + pointer in, one-hot grant out, combinational).

Verification
REQ-034 Req0 only, op=0000, a=0xFFFFFFFF, b=1 -> rsp_valid[0] at cycle N+2 (ALU_LAT=1), rsp_data=0, rsp_zero=1, rsp_carry=1.
REQ-035 Req0 and req1 held valid for 4 operations, RR_EN defined -> grant order 0,1,0,1; undefined -> 0,0,0,0.
REQ-036 op=1010, a=5, b=7 -> rsp_data=0xFFFFFFFE, rsp_sign=1, rsp_carry=0.
REQ-037 rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_data stable, busy=1, req_ready stays 0.
REQ-038 Reset low during EXEC -> all outputs 0 immediately; after release with no req_valid, rsp_valid stays 0.
REQ-039 ALU_LAT=3, op=1001, a=0xF0, b=0x0F -> rsp_valid at N+4, rsp_data=0xFF, rsp_zero=0.
